video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_if.sv | 27 ++
 rtl/video_cen_div.sv | 44 ++++
 rtl/video_timing_gen.sv | 123 ++++++++++++
 tb/tb_video_timing_gen.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared defaults and helpers for the raster timing generator.
// Optional feature macro used by the generator: VIDEO_TIMING_INTERLACE_EN.
package video_timing_pkg;

  localparam int CNTW_DEF     = 10;
  localparam int CEN_DIV_DEF  = 8;
  localparam int HTOTAL_DEF   = 320;
  localparam int HB_START_DEF = 256;
  localparam int HB_END_DEF   = 0;
  localparam int HS_START_DEF = 276;
  localparam int HS_END_DEF   = 300;
  localparam int VTOTAL_DEF   = 262;
  localparam int VB_START_DEF = 224;
  localparam int VB_END_DEF   = 0;
  localparam int VS_START_DEF = 234;
  localparam int VS_END_DEF   = 237;

  // Effective horizontal value: doubled in high-res, then truncated to cntw bits.
  // A doubled HTOTAL of exactly 2^cntw wraps to 0, and "tot - 1" still yields the last pixel.
  function automatic logic [31:0] eff_h(input int unsigned val, input logic hres,
                                        input int unsigned cntw);
    logic [31:0] v;
    v = hres ? (val << 1) : val;
    return v & ((32'd1 << cntw) - 32'd1);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle: generator drives the master side, video consumers take the slave side.
interface video_timing_if
  import video_timing_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
);
  logic            hres_mode;
  logic            pxl_cen;
  logic            hs;
  logic            vs;
  logic            LHBL;
  logic            LVBL;
  logic [CNTW-1:0] hcnt;
  logic [CNTW-1:0] vcnt;
  logic            field;
  logic            hres;

  modport master (
    input  hres_mode,
    output pxl_cen, hs, vs, LHBL, LVBL, hcnt, vcnt, field, hres
  );

  modport slave (
    output hres_mode,
    input  pxl_cen, hs, vs, LHBL, LVBL, hcnt, vcnt, field, hres
  );
endinterface

// File: rtl/video_cen_div.sv
// Pixel clock-enable divider: one-clk pulse every DIV clocks, or DIV/2 when i_half is set.
module video_cen_div
  import video_timing_pkg::*;
#(
  parameter int DIV = CEN_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_half,
  output logic o_cen
);
  localparam int           W         = $clog2(DIV);
  localparam logic [W-1:0] LAST_FULL = W'(DIV - 1);
  localparam logic [W-1:0] LAST_HALF = W'(DIV / 2 - 1);

  logic [W-1:0] r_cnt;
  logic         r_cen;
  logic [W-1:0] w_last;

  assign w_last = i_half ? LAST_HALF : LAST_FULL;

  // NOTE: reset is sampled synchronously and all state uses non-blocking assignments,
  // so every register here and in the generator updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_cen <= 1'b0;
    end else if (i_restart) begin
      // Restarting edge counts as the first clock of a new period under the new divisor.
      r_cnt <= W'(1);
      r_cen <= 1'b0;
    end else if (r_cnt >= w_last) begin
      r_cnt <= '0;
      r_cen <= 1'b1;
    end else begin
      r_cnt <= r_cnt + W'(1);
      r_cen <= 1'b0;
    end
  end

  assign o_cen = r_cen;

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel enable, H/V counters, syncs and blanking.
// Optional: define VIDEO_TIMING_INTERLACE_EN for alternating fields with half-line vs offset.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CNTW     = CNTW_DEF,
  parameter int CEN_DIV  = CEN_DIV_DEF,
  parameter int HTOTAL   = HTOTAL_DEF,
  parameter int HB_START = HB_START_DEF,
  parameter int HB_END   = HB_END_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_END   = HS_END_DEF,
  parameter int VTOTAL   = VTOTAL_DEF,
  parameter int VB_START = VB_START_DEF,
  parameter int VB_END   = VB_END_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_END   = VS_END_DEF
) (
  input logic          clk,
  input logic          rst_n,
  video_timing_if.master vid
);
  localparam logic [CNTW-1:0] VB_S = CNTW'(VB_START);
  localparam logic [CNTW-1:0] VB_E = CNTW'(VB_END);
  localparam logic [CNTW-1:0] VS_S = CNTW'(VS_START);
  localparam logic [CNTW-1:0] VS_E = CNTW'(VS_END);

  logic            r_hres, r_field, r_hs, r_vs, r_lhbl, r_lvbl;
  logic [CNTW-1:0] r_hcnt, r_vcnt;

  logic            w_cen, w_h_last, w_v_last, w_frame_wrap, w_vs_line;
  logic [CNTW-1:0] w_htot, w_hb_s, w_hb_e, w_hs_s, w_hs_e;
  logic [CNTW-1:0] w_vlast, w_hnext, w_vnext;

  assign w_htot = CNTW'(eff_h(HTOTAL,   r_hres, CNTW));
  assign w_hb_s = CNTW'(eff_h(HB_START, r_hres, CNTW));
  assign w_hb_e = CNTW'(eff_h(HB_END,   r_hres, CNTW));
  assign w_hs_s = CNTW'(eff_h(HS_START, r_hres, CNTW));
  assign w_hs_e = CNTW'(eff_h(HS_END,   r_hres, CNTW));

`ifdef VIDEO_TIMING_INTERLACE_EN
  logic [CNTW-1:0] w_hhalf;
  assign w_hhalf   = r_hres ? CNTW'(HTOTAL) : CNTW'(HTOTAL / 2);
  assign w_vlast   = r_field ? CNTW'(VTOTAL) : CNTW'(VTOTAL - 1);
  assign w_vs_line = ~r_field;
`else
  assign w_vlast   = CNTW'(VTOTAL - 1);
  assign w_vs_line = 1'b1;
`endif

  assign w_h_last     = (r_hcnt == w_htot - CNTW'(1));
  assign w_v_last     = (r_vcnt == w_vlast);
  assign w_hnext      = w_h_last ? '0 : r_hcnt + CNTW'(1);
  assign w_vnext      = w_v_last ? '0 : r_vcnt + CNTW'(1);
  assign w_frame_wrap = w_cen & w_h_last & w_v_last;

  video_cen_div #(.DIV(CEN_DIV)) u_cen_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_restart(w_frame_wrap),
    .i_half   (r_hres),
    .o_cen    (w_cen)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_lhbl  <= 1'b0;
      r_lvbl  <= 1'b0;
      r_field <= 1'b0;
      r_hres  <= vid.hres_mode;
    end else if (w_cen) begin
      r_hcnt <= w_hnext;
      // Equal START/END means the output is frozen, so both matches are ignored.
      if (w_hb_s != w_hb_e) begin
        if (w_hnext == w_hb_s)      r_lhbl <= 1'b0;
        else if (w_hnext == w_hb_e) r_lhbl <= 1'b1;
      end
      if (w_hs_s != w_hs_e) begin
        if (w_hnext == w_hs_s)      r_hs <= 1'b1;
        else if (w_hnext == w_hs_e) r_hs <= 1'b0;
      end
      if (w_h_last) begin
        r_vcnt <= w_vnext;
        if (VB_S != VB_E) begin
          if (w_vnext == VB_S)      r_lvbl <= 1'b0;
          else if (w_vnext == VB_E) r_lvbl <= 1'b1;
        end
        if (w_vs_line && VS_S != VS_E) begin
          if (w_vnext == VS_S)      r_vs <= 1'b1;
          else if (w_vnext == VS_E) r_vs <= 1'b0;
        end
        if (w_v_last) begin
          r_hres <= vid.hres_mode;
`ifdef VIDEO_TIMING_INTERLACE_EN
          r_field <= ~r_field;
`endif
        end
      end
`ifdef VIDEO_TIMING_INTERLACE_EN
      // Field 1 moves the vs edges to mid-line of the same lines.
      if (r_field && VS_S != VS_E && w_hnext == w_hhalf) begin
        if (r_vcnt == VS_S)      r_vs <= 1'b1;
        else if (r_vcnt == VS_E) r_vs <= 1'b0;
      end
`endif
    end
  end

  assign vid.pxl_cen = w_cen;
  assign vid.hcnt    = r_hcnt;
  assign vid.vcnt    = r_vcnt;
  assign vid.hs      = r_hs;
  assign vid.vs      = r_vs;
  assign vid.LHBL    = r_lhbl;
  assign vid.LVBL    = r_lvbl;
  assign vid.field   = r_field;
  assign vid.hres    = r_hres;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small 16x10 raster with CEN_DIV=4.
// With VIDEO_TIMING_INTERLACE_EN defined, field-1 frames and half-line vs are also expected.
module tb_video_timing_gen;
  localparam int CNTW = 10;
`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam int VS_E_P = 7;
  localparam bit F1     = 1'b1;
`else
  localparam int VS_E_P = 5;
  localparam bit F1     = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_if #(.CNTW(CNTW)) vid ();

  video_timing_gen #(
    .CNTW(CNTW), .CEN_DIV(4), .HTOTAL(16), .HB_START(12), .HB_END(2),
    .HS_START(13), .HS_END(15), .VTOTAL(10), .VB_START(8), .VB_END(1),
    .VS_START(5), .VS_END(VS_E_P)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vid  (vid)
  );

  typedef struct packed {
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hs, vs, lhbl, lvbl, field, hres;
    logic [7:0] gap;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0, last_cyc = 0, n_seen = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected per-enable raster state for one frame, from hand-derived window ranges.
  task automatic push_frame(input bit hr, input bit fld, input int max_n);
    int htot = hr ? 32 : 16;
    int hbs  = hr ? 24 : 12;
    int hbe  = hr ? 4 : 2;
    int hss  = hr ? 26 : 13;
    int hse  = hr ? 30 : 15;
    int half = htot / 2;
    int vt   = fld ? 11 : 10;
    int n    = 0;
    for (int v = 0; v < vt; v++) begin
      for (int h = 0; h < htot; h++) begin
        obs_t e;
        if (n >= max_n) return;
        e.hcnt  = 10'(h);
        e.vcnt  = 10'(v);
        e.hs    = (h >= hss) && (h < hse);
        e.lhbl  = !((h >= hbs) || (h < hbe));
        e.lvbl  = (v >= 1) && (v < 8);
`ifdef VIDEO_TIMING_INTERLACE_EN
        if (!fld) e.vs = (v >= 5) && (v < 7);
        else      e.vs = (v == 5 && h >= half) || (v == 6) || (v == 7 && h < half);
`else
        e.vs    = 1'b0;
`endif
        e.field = fld;
        e.hres  = hr;
        e.gap   = hr ? 8'd2 : 8'd4;
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  // Monitor: every pxl_cen pops one expected pixel and compares, including the clk gap.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done) break;
      if (!rst_n) begin
        last_cyc = cyc;
      end else if (vid.pxl_cen) begin
        obs_t a, e;
        int   g;
        g        = cyc - last_cyc;
        last_cyc = cyc;
        a.hcnt   = vid.hcnt;
        a.vcnt   = vid.vcnt;
        a.hs     = vid.hs;
        a.vs     = vid.vs;
        a.lhbl   = vid.LHBL;
        a.lvbl   = vid.LVBL;
        a.field  = vid.field;
        a.hres   = vid.hres;
        a.gap    = (g > 255) ? 8'hFF : 8'(g);
        check("cen_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("pix%0d", n_seen), 64'(a), 64'(e));
        end
        n_seen++;
      end
    end
  end

  task automatic wait_seen(input int target, input int budget);
    int k = 0;
    while (n_seen < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_seen", 64'(n_seen >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({vid.pxl_cen, vid.hs, vid.vs, vid.LHBL, vid.LVBL, vid.field, vid.hres,
                vid.hcnt, vid.vcnt});
  endfunction

  initial begin : stim
    vid.hres_mode = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);

    // Frame 0 low-res, frame 1 high-res (field 1 if interlaced), frame 2 up to h=7 v=3.
    push_frame(1'b0, 1'b0, 160);
    push_frame(1'b1, F1, 1000);
    push_frame(1'b0, 1'b0, 56);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_before_first_cen", all_outs(), 64'd0);

    wait_seen(80, 2000);
    vid.hres_mode = 1'b1;
    wait_seen(240, 4000);
    vid.hres_mode = 1'b0;
    wait_drain(5000);

    // Mid-line reset: everything back to reset values on the very next edge.
    check("pre_reset_pos", 64'({vid.vcnt, vid.hcnt}), 64'({10'd3, 10'd7}));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_line", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    push_frame(1'b0, 1'b0, 40);
    #1 rst_n = 1'b1;
    wait_drain(1000);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
